// File: rtl/sort_engine.sv
// sort_engine: in-place bubble sort with early exit over an external
// dual-port RAM (one-cycle synchronous read). Port A carries element i and
// port B carries element i+1. A swap is written back crosswise on both ports
// in the compare cycle, at the addresses that were just read.

// Order comparator: flags a pair (a at i, b at i+1) that must be swapped.
// Equal keys never swap, which keeps the sort stable.
module sort_cmp #(
    parameter int DWIDTH = 8,
    parameter int SIGNED = 0
) (
    input  logic              descending,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic              out_of_order
);
    logic a_gt_b;
    logic a_lt_b;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_gt_b = $signed(a) > $signed(b);
            assign a_lt_b = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign a_gt_b = a > b;
            assign a_lt_b = a < b;
        end
    endgenerate

    assign out_of_order = descending ? a_lt_b : a_gt_b;
endmodule

module sort_engine #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 10,
    parameter int SIGNED = 0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic              descending_i,
    input  logic [AWIDTH-1:0] data_size_i,
    output logic [AWIDTH-1:0] a_addr_o,
    output logic              a_wr_en_o,
    output logic [DWIDTH-1:0] a_wr_data_o,
    input  logic [DWIDTH-1:0] a_rd_data_i,
    output logic [AWIDTH-1:0] b_addr_o,
    output logic              b_wr_en_o,
    output logic [DWIDTH-1:0] b_wr_data_o,
    input  logic [DWIDTH-1:0] b_rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AWIDTH-1:0] pass_cnt_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AWIDTH-1:0] A_ZERO = '0;
    localparam logic [AWIDTH-1:0] A_ONE  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] A_TWO  = AWIDTH'(2);
    localparam logic [AWIDTH:0]   W_ONE  = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0]   W_TWO  = (AWIDTH+1)'(2);

    logic [1:0]        state;
    logic [AWIDTH-1:0] n_q;        // element count latched at start
    logic              desc_q;     // order latched at start
    logic [AWIDTH-1:0] i_q;        // index of the left element of the pair
    logic [AWIDTH-1:0] j_q;        // pass number within this run
    logic              swapped_q;  // any swap so far in the current pass
    logic              empty_q;    // n < 2: one busy cycle before done

    // Loop bounds are evaluated one bit wider so n-2-j cannot wrap.
    logic [AWIDTH:0] n_w;
    logic [AWIDTH:0] i_w;
    logic [AWIDTH:0] j_w;
    logic [AWIDTH:0] limit_w;
    logic            more_cmp;
    logic            last_pass;
    logic            out_of_order;
    logic            swap_now;
    logic            pass_dirty;
    logic            size_small;

    assign n_w       = {1'b0, n_q};
    assign i_w       = {1'b0, i_q};
    assign j_w       = {1'b0, j_q};
    assign limit_w   = n_w - W_TWO - j_w;
    assign more_cmp  = i_w < limit_w;
    assign last_pass = (j_w + W_ONE) == (n_w - W_ONE);
    assign size_small = {1'b0, data_size_i} < W_TWO;

    sort_cmp #(
        .DWIDTH (DWIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .descending   (desc_q),
        .a            (a_rd_data_i),
        .b            (b_rd_data_i),
        .out_of_order (out_of_order)
    );

    // Writes are decoded straight from the state register so that an
    // asynchronous reset kills an in-flight write in the same cycle.
    assign swap_now    = (state == CMP) && out_of_order;
    assign pass_dirty  = swapped_q || swap_now;
    assign a_wr_en_o   = swap_now;
    assign b_wr_en_o   = swap_now;
    assign a_wr_data_o = b_rd_data_i;
    assign b_wr_data_o = a_rd_data_i;

    // A run shorter than two elements still shows one busy cycle, so the
    // handshake looks the same to the controller whatever the size.
    assign busy_o = (state == RD) || (state == CMP) || ((state == DONE) && empty_q);
    assign done_o = (state == DONE) && !empty_q;

    // Sort sequencer: issues one pair read per RD, decides and writes in CMP,
    // advances i within a pass and j across passes, exits early on a clean pass.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= IDLE;
            n_q        <= A_ZERO;
            desc_q     <= 1'b0;
            i_q        <= A_ZERO;
            j_q        <= A_ZERO;
            swapped_q  <= 1'b0;
            empty_q    <= 1'b0;
            pass_cnt_o <= A_ZERO;
            a_addr_o   <= A_ZERO;
            b_addr_o   <= A_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        n_q        <= data_size_i;
                        desc_q     <= descending_i;
                        i_q        <= A_ZERO;
                        j_q        <= A_ZERO;
                        swapped_q  <= 1'b0;
                        pass_cnt_o <= A_ZERO;
                        a_addr_o   <= A_ZERO;
                        b_addr_o   <= A_ONE;
                        if (size_small) begin
                            empty_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state   <= RD;
                        end
                    end
                end
                RD: begin
                    state <= CMP;
                end
                CMP: begin
                    if (more_cmp) begin
                        swapped_q <= pass_dirty;
                        i_q       <= i_q + A_ONE;
                        a_addr_o  <= i_q + A_ONE;
                        b_addr_o  <= i_q + A_TWO;
                        state     <= RD;
                    end else begin
                        pass_cnt_o <= pass_cnt_o + A_ONE;
                        if (!pass_dirty || last_pass) begin
                            swapped_q <= pass_dirty;
                            state     <= DONE;
                        end else begin
                            swapped_q <= 1'b0;
                            j_q       <= j_q + A_ONE;
                            i_q       <= A_ZERO;
                            a_addr_o  <= A_ZERO;
                            b_addr_o  <= A_ONE;
                            state     <= RD;
                        end
                    end
                end
                DONE: begin
                    if (empty_q) begin
                        empty_q <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised in-place sorter that runs bubble sort with early exit over an external dual-port RAM with a one-cycle synchronous read. It sorts in ascending or descending order, with signed or unsigned comparison, and uses a start/busy/done handshake. It sits between the sorting controller and the shared data RAM, and drives both RAM ports for the whole of a run.

## Interface
- DWIDTH, 8: element width in bits.
- AWIDTH, 10: RAM address width; element count is 0..2^AWIDTH-1.
- SIGNED, 0: 1 = two's-complement comparison, 0 = unsigned.
- clk_i  in  1  clock; all logic on rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE.
- descending_i  in  1  order select; latched at start.
- data_size_i  in  AWIDTH  element count n; latched at start.
- a_addr_o  out  AWIDTH  port A address (element i); registered.
- a_wr_en_o  out  1  port A write enable.
- a_wr_data_o  out  DWIDTH  port A write data (= b_rd_data_i).
- a_rd_data_i  in  DWIDTH  port A read data, valid one cycle after address.
- b_addr_o  out  AWIDTH  port B address (element i+1); registered.
- b_wr_en_o  out  1  port B write enable (always equal to a_wr_en_o).
- b_wr_data_o  out  DWIDTH  port B write data (= a_rd_data_i).
- b_rd_data_i  in  DWIDTH  port B read data.
- busy_o  out  1  high from the cycle after an accepted start until DONE.
- done_o  out  1  one-cycle pulse when the array is sorted.
- pass_cnt_o  out  AWIDTH  passes executed in the last/current run; holds after done.

## Operation
- FSM states: IDLE, RD, CMP, DONE.
- IDLE: if start_i, latch n and order, clear j, i and pass_cnt_o. If n < 2 go to DONE, else go to RD.
- RD: a_addr_o = i, b_addr_o = i+1 are registered on entry. The cycle is spent on the RAM read latency. Next state is CMP.
- CMP: read data is valid.
  - Out-of-order condition is a > b (ascending) or a < b (descending), signed or unsigned per SIGNED.
  - Equal elements are never swapped, so the sort is stable.
  - If out of order: a_wr_en_o = b_wr_en_o = 1 this cycle and the pass swap flag is set. Addresses are unchanged, so the swap is written in place.
- End of comparison in CMP:
  - If i < n-2-j: i <= i+1, go to RD.
  - Else the pass is done: pass_cnt_o increments.
  - If the swap flag was clear (including the swap just made in this CMP) or j+1 = n-1: go to DONE.
  - Otherwise j <= j+1, i <= 0, clear the swap flag, go to RD.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- Width rules: compare with i, j, n widened to AWIDTH+1 bits so n-2-j never wraps. n = 2^AWIDTH-1 is legal.
- start_i is ignored in RD, CMP and DONE. latched n and order are immune to input changes mid-run.
- Reset (any time, including mid-run):
  - Immediately go to IDLE.
  - a_wr_en_o = b_wr_en_o = 0, busy_o = 0, done_o = 0.
  - Addresses 0, pass_cnt_o 0, i = j = 0, swap flag 0.
  - A write in flight is abandoned; RAM contents are undefined but no further writes occur.
  - Write-data outputs are combinational pass-throughs of read data and carry no reset value.

## Timing
- Start accepted at edge t: busy_o high from t+1, first address on the bus at t+1, first possible write at t+2.
- Each comparison takes 2 cycles (RD+CMP). A pass of m comparisons takes 2m cycles.
- Run length from start to done_o:
  - 1 (IDLE→RD entry) + 2·Σ over executed passes of (n-1-j), then DONE.
  - done_o is asserted in the cycle after the last CMP.
- n < 2: done_o two cycles after the start edge, no RAM writes, pass_cnt_o = 0.
- Already-sorted input of n elements: exactly one pass, 2(n-1) compare cycles, pass_cnt_o = 1, no writes.
- busy_o falls in the same cycle done_o rises. A new start may be accepted the cycle after done_o.
- Writes occur only in CMP cycles. Never more than one write per port per 2 cycles.

## Test plan
- Ascending, unsigned, n=5, RAM {5,4,3,2,1}:
  - Result {1,2,3,4,5}, pass_cnt_o=4 (the j+1=n-1 limit ends the run), 10 swaps.
  - done_o at cycle 1+2·(4+3+2+1)=21 after start.
- Early exit, n=6, {1,2,3,4,6,5}: one swap in pass 0, pass 1 clean, pass_cnt_o=2, result {1,2,3,4,5,6}.
- Descending + SIGNED=1, DWIDTH=8, n=4, {0x80,0x7F,0x00,0xFF}: result {0x7F,0x00,0xFF,0x80} (127,0,-1,-128).
- Stability/equal keys, n=4, {3,3,3,3}: no write enables ever asserted, pass_cnt_o=1, done_o after 1+6 cycles.
- Boundaries:
  - n=0 and n=1: done_o pulse 2 cycles after start, busy_o high 1 cycle, no writes.
  - n=2 with {9,1}: single swap, result {1,9}.
- Reset mid-run: assert arst_i during a CMP swap cycle → wr_en, busy_o and done_o drop immediately. After release, FSM is in IDLE, a fresh start sorts correctly, and start_i pulses during a run are ignored.
